// File: rtl/multicycle_ctrl_if.sv
// Control/status bundle between the multicycle controller and its datapath/memory.
// The master side is the controller; the slave side is the datapath that supplies op/funct and mem_ack.
interface multicycle_ctrl_if;
    logic [5:0]  op;
    logic [5:0]  funct;
    logic        mem_ack;
    logic        ir_wr;
    logic        pc_wr;
    logic [1:0]  pc_src;
    logic        reg_wr;
    logic [1:0]  wb_sel;
    logic [1:0]  alu_op;
    logic        mem_req;
    logic        mem_we;
    logic        illegal;
    logic [31:0] retired;
    logic [3:0]  state;

    modport master (
        input  op, funct, mem_ack,
        output ir_wr, pc_wr, pc_src, reg_wr, wb_sel, alu_op,
               mem_req, mem_we, illegal, retired, state
    );

    modport slave (
        output op, funct, mem_ack,
        input  ir_wr, pc_wr, pc_src, reg_wr, wb_sel, alu_op,
               mem_req, mem_we, illegal, retired, state
    );
endinterface

// File: rtl/multicycle_ctrl.sv
// Multicycle MIPS-subset control FSM: sequences fetch/decode/execute/memory/write-back
// and counts retired instructions.
module multicycle_ctrl (
    input  logic              clk,
    input  logic              rst,
    multicycle_ctrl_if.master bus
);
    typedef enum logic [3:0] {
        FETCH    = 4'd0,
        DECODE   = 4'd1,
        EXEC_R   = 4'd2,
        EXEC_I   = 4'd3,
        MEM_ADDR = 4'd4,
        MEM_RD   = 4'd5,
        MEM_WR   = 4'd6,
        WB       = 4'd7,
        BRANCH   = 4'd8,
        JUMP     = 4'd9,
        JR       = 4'd10,
        ILLEGAL  = 4'd11
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] FN_JR    = 6'b001000;

    state_t      state_reg;
    logic [31:0] retired_reg;

    logic        ir_wr_c;
    logic        pc_wr_c;
    logic [1:0]  pc_src_c;
    logic        reg_wr_c;
    logic [1:0]  wb_sel_c;
    logic [1:0]  alu_op_c;
    logic        mem_req_c;
    logic        mem_we_c;
    logic        illegal_c;
    logic        xfer_done;
    state_t      decode_next;

    // mem_req_c is already zero outside memory states, so stray acks are ignored
    assign xfer_done = mem_req_c & bus.mem_ack;

    always_comb begin
        decode_next = ILLEGAL;
        case (bus.op)
            OP_RTYPE: begin
                case (bus.funct)
                    FN_JR:     decode_next = JR;
                    6'b100000,
                    6'b100010,
                    6'b100100,
                    6'b100101,
                    6'b101010: decode_next = EXEC_R;
                    default:   decode_next = ILLEGAL;
                endcase
            end
            OP_ADDI, OP_ORI: decode_next = EXEC_I;
            OP_LW, OP_SW:    decode_next = MEM_ADDR;
            OP_BEQ:          decode_next = BRANCH;
            OP_J:            decode_next = JUMP;
            default:         decode_next = ILLEGAL;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg   <= FETCH;
            retired_reg <= 32'd0;
        end else begin
            if (pc_wr_c && state_reg != ILLEGAL)
                retired_reg <= retired_reg + 32'd1;
            case (state_reg)
                FETCH:    state_reg <= xfer_done ? DECODE : FETCH;
                DECODE:   state_reg <= decode_next;
                EXEC_R:   state_reg <= WB;
                EXEC_I:   state_reg <= WB;
                MEM_ADDR: state_reg <= (bus.op == OP_SW) ? MEM_WR : MEM_RD;
                MEM_RD:   state_reg <= xfer_done ? WB : MEM_RD;
                MEM_WR:   state_reg <= xfer_done ? FETCH : MEM_WR;
                WB:       state_reg <= FETCH;
                BRANCH:   state_reg <= FETCH;
                JUMP:     state_reg <= FETCH;
                JR:       state_reg <= FETCH;
                ILLEGAL:  state_reg <= FETCH;
                default:  state_reg <= FETCH;
            endcase
        end
    end

    // Outputs decode from the state register; reset masks them immediately,
    // including an in-flight memory request.
    always_comb begin
        ir_wr_c   = 1'b0;
        pc_wr_c   = 1'b0;
        pc_src_c  = 2'b00;
        reg_wr_c  = 1'b0;
        wb_sel_c  = 2'b00;
        alu_op_c  = 2'b00;
        mem_req_c = 1'b0;
        mem_we_c  = 1'b0;
        illegal_c = 1'b0;
        if (!rst) begin
            case (state_reg)
                FETCH: begin
                    mem_req_c = 1'b1;
                    ir_wr_c   = bus.mem_ack;
                end
                EXEC_R: alu_op_c = 2'b10;
                EXEC_I: alu_op_c = (bus.op == OP_ORI) ? 2'b11 : 2'b00;
                MEM_RD: mem_req_c = 1'b1;
                MEM_WR: begin
                    mem_req_c = 1'b1;
                    mem_we_c  = 1'b1;
                    pc_wr_c   = bus.mem_ack;
                end
                WB: begin
                    reg_wr_c = 1'b1;
                    pc_wr_c  = 1'b1;
                    if (bus.op == OP_RTYPE)
                        wb_sel_c = 2'b00;
                    else if (bus.op == OP_LW)
                        wb_sel_c = 2'b10;
                    else
                        wb_sel_c = 2'b01;
                end
                BRANCH: begin
                    alu_op_c = 2'b01;
                    pc_wr_c  = 1'b1;
                    pc_src_c = 2'b01;
                end
                JUMP: begin
                    pc_wr_c  = 1'b1;
                    pc_src_c = 2'b10;
                end
                JR: begin
                    pc_wr_c  = 1'b1;
                    pc_src_c = 2'b11;
                end
                ILLEGAL: begin
                    illegal_c = 1'b1;
                    pc_wr_c   = 1'b1;
                end
                default: begin
                    pc_wr_c = 1'b0;
                end
            endcase
        end
    end

    assign bus.ir_wr   = ir_wr_c;
    assign bus.pc_wr   = pc_wr_c;
    assign bus.pc_src  = pc_src_c;
    assign bus.reg_wr  = reg_wr_c;
    assign bus.wb_sel  = wb_sel_c;
    assign bus.alu_op  = alu_op_c;
    assign bus.mem_req = mem_req_c;
    assign bus.mem_we  = mem_we_c;
    assign bus.illegal = illegal_c;
    assign bus.retired = retired_reg;
    assign bus.state   = state_reg;
endmodule

// File: tb/tb_multicycle_ctrl.sv
// Directed bench for multicycle_ctrl: table of instructions with hand-computed
// outcomes, plus hand-written reset, wait-state and counter-wrap sequences.
module tb_multicycle_ctrl;
    logic clk;
    logic rst;
    multicycle_ctrl_if bus();

    multicycle_ctrl dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;
    logic [3:0] seq [64];

    typedef struct {
        logic [5:0] op;
        logic [5:0] funct;
        int         waits;
        int         cyc;
        logic [1:0] pc_src;
        int         regw;
        logic [1:0] wb;
        logic [1:0] alu2;
        int         ill;
        logic [31:0] inc;
        logic       we;
    } vec_t;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Acts as memory with a fixed number of wait cycles per access; runs one
    // instruction from FETCH until the cycle after its pc_wr.
    task automatic run_instr(input logic [5:0] op, input logic [5:0] funct, input int waits,
                             output int cyc, output int pcw, output int regw, output int ill,
                             output logic [1:0] pcs, output logic [1:0] wb, output logic [1:0] alu2,
                             output logic we, output logic [3:0] endst, output logic [31:0] delta);
        int wcnt;
        logic [31:0] r0;
        bit done;
        cyc = 0; pcw = 0; regw = 0; ill = 0; pcs = 0; wb = 0; alu2 = 0; we = 0;
        wcnt = 0; done = 0;
        bus.op = op;
        bus.funct = funct;
        r0 = bus.retired;
        while (!done && cyc < 60) begin
            @(negedge clk);
            bus.mem_ack = bus.mem_req && (wcnt == waits);
            #1;
            seq[cyc] = bus.state;
            if (cyc == 2) alu2 = bus.alu_op;
            if (bus.pc_wr) begin
                pcw++;
                pcs = bus.pc_src;
                we = bus.mem_we;
                done = 1;
            end
            if (bus.reg_wr) begin
                regw++;
                wb = bus.wb_sel;
            end
            if (bus.illegal) ill++;
            if (bus.mem_req) wcnt = bus.mem_ack ? 0 : wcnt + 1;
            cyc++;
        end
        @(posedge clk);
        #1;
        bus.mem_ack = 1'b0;
        endst = bus.state;
        if (bus.pc_wr) pcw++;
        delta = bus.retired - r0;
    endtask

    vec_t v [15];
    int cyc, pcw, regw, ill;
    logic [1:0] pcs, wb, alu2;
    logic we;
    logic [3:0] endst;
    logic [31:0] delta;
    logic [3:0] exp_st [5];
    logic [3:0] lw_seq [9];
    bit found;

    initial begin
        //          op         funct      w  cyc pcs reg wb  alu ill inc we
        v[0]  = '{6'b000000, 6'b100000, 0, 4, 2'd0, 1, 2'd0, 2'd2, 0, 1, 1'b0}; // add
        v[1]  = '{6'b000000, 6'b100010, 0, 4, 2'd0, 1, 2'd0, 2'd2, 0, 1, 1'b0}; // sub
        v[2]  = '{6'b000000, 6'b101010, 0, 4, 2'd0, 1, 2'd0, 2'd2, 0, 1, 1'b0}; // slt
        v[3]  = '{6'b001000, 6'b000000, 0, 4, 2'd0, 1, 2'd1, 2'd0, 0, 1, 1'b0}; // addi
        v[4]  = '{6'b001101, 6'b111111, 0, 4, 2'd0, 1, 2'd1, 2'd3, 0, 1, 1'b0}; // ori
        v[5]  = '{6'b100011, 6'b000000, 0, 5, 2'd0, 1, 2'd2, 2'd0, 0, 1, 1'b0}; // lw
        v[6]  = '{6'b101011, 6'b000000, 0, 4, 2'd0, 0, 2'd0, 2'd0, 0, 1, 1'b1}; // sw
        v[7]  = '{6'b000100, 6'b000000, 0, 3, 2'd1, 0, 2'd0, 2'd1, 0, 1, 1'b0}; // beq
        v[8]  = '{6'b000010, 6'b000000, 0, 3, 2'd2, 0, 2'd0, 2'd0, 0, 1, 1'b0}; // j
        v[9]  = '{6'b000000, 6'b001000, 0, 3, 2'd3, 0, 2'd0, 2'd0, 0, 1, 1'b0}; // jr
        v[10] = '{6'b111111, 6'b000000, 0, 3, 2'd0, 0, 2'd0, 2'd0, 1, 0, 1'b0}; // illegal op
        v[11] = '{6'b000000, 6'b000001, 0, 3, 2'd0, 0, 2'd0, 2'd0, 1, 0, 1'b0}; // illegal funct
        v[12] = '{6'b100011, 6'b000000, 2, 9, 2'd0, 1, 2'd2, 2'd0, 0, 1, 1'b0}; // lw, 2 waits
        v[13] = '{6'b101011, 6'b000000, 1, 6, 2'd0, 0, 2'd0, 2'd0, 0, 1, 1'b1}; // sw, 1 wait
        v[14] = '{6'b000000, 6'b100101, 0, 4, 2'd0, 1, 2'd0, 2'd2, 0, 1, 1'b0}; // or

        exp_st[0] = 4'd0; exp_st[1] = 4'd1; exp_st[2] = 4'd2; exp_st[3] = 4'd7; exp_st[4] = 4'd0;
        lw_seq[0] = 4'd0; lw_seq[1] = 4'd0; lw_seq[2] = 4'd0; lw_seq[3] = 4'd1; lw_seq[4] = 4'd4;
        lw_seq[5] = 4'd5; lw_seq[6] = 4'd5; lw_seq[7] = 4'd5; lw_seq[8] = 4'd7;

        // Reset state, with mem_ack already tied high
        rst = 1'b1;
        bus.mem_ack = 1'b1;
        bus.op = 6'b000000;
        bus.funct = 6'b100000;
        repeat (2) @(negedge clk);
        #1;
        chk("rst_state", 32'(bus.state), 32'd0);
        chk("rst_retired", bus.retired, 32'd0);
        chk("rst_mem_req", 32'(bus.mem_req), 32'd0);
        chk("rst_ir_wr", 32'(bus.ir_wr), 32'd0);
        chk("rst_pc_wr", 32'(bus.pc_wr), 32'd0);

        @(negedge clk);
        rst = 1'b0;
        for (int k = 0; k < 5; k++) begin
            #1;
            chk($sformatf("add_tied_state%0d", k), 32'(bus.state), 32'(exp_st[k]));
            if (k == 0) chk("add_tied_mem_req", 32'(bus.mem_req), 32'd1);
            if (k == 1) chk("decode_ack_ignored_ir_wr", 32'(bus.ir_wr), 32'd0);
            if (k == 3) begin
                chk("add_tied_reg_wr", 32'(bus.reg_wr), 32'd1);
                chk("add_tied_pc_wr", 32'(bus.pc_wr), 32'd1);
                chk("add_tied_wb_sel", 32'(bus.wb_sel), 32'd0);
                chk("add_tied_pc_src", 32'(bus.pc_src), 32'd0);
            end
            if (k == 4) begin
                chk("add_tied_retired", bus.retired, 32'd1);
                bus.mem_ack = 1'b0;
            end
            if (k < 4) @(negedge clk);
        end
        $display("txn add (mem_ack tied): retired=%0d", bus.retired);

        // Table-driven instruction vectors
        for (int i = 0; i < 15; i++) begin
            run_instr(v[i].op, v[i].funct, v[i].waits, cyc, pcw, regw, ill, pcs, wb, alu2, we, endst, delta);
            $display("txn %0d: op=%b funct=%b waits=%0d cycles=%0d pc_src=%0d reg_wr=%0d wb_sel=%0d illegal=%0d retired=%0d",
                     i, v[i].op, v[i].funct, v[i].waits, cyc, pcs, regw, wb, ill, bus.retired);
            chk($sformatf("v%0d_cycles", i), 32'(cyc), 32'(v[i].cyc));
            chk($sformatf("v%0d_pc_wr_count", i), 32'(pcw), 32'd1);
            chk($sformatf("v%0d_pc_src", i), 32'(pcs), 32'(v[i].pc_src));
            chk($sformatf("v%0d_reg_wr_count", i), 32'(regw), 32'(v[i].regw));
            chk($sformatf("v%0d_wb_sel", i), 32'(wb), 32'(v[i].wb));
            chk($sformatf("v%0d_alu_op_c3", i), 32'(alu2), 32'(v[i].alu2));
            chk($sformatf("v%0d_illegal_count", i), 32'(ill), 32'(v[i].ill));
            chk($sformatf("v%0d_mem_we_at_pc_wr", i), 32'(we), 32'(v[i].we));
            chk($sformatf("v%0d_end_state", i), 32'(endst), 32'd0);
            chk($sformatf("v%0d_retired_delta", i), delta, v[i].inc);
            if (i == 12) begin
                for (int k = 0; k < 9; k++)
                    chk($sformatf("lw_wait_state%0d", k), 32'(seq[k]), 32'(lw_seq[k]));
            end
        end

        // Retired counter wrap
        force dut.retired_reg = 32'hFFFF_FFFF;
        #1;
        release dut.retired_reg;
        chk("wrap_preload", bus.retired, 32'hFFFF_FFFF);
        run_instr(6'b000000, 6'b100000, 0, cyc, pcw, regw, ill, pcs, wb, alu2, we, endst, delta);
        $display("txn wrap add: retired=0x%08h", bus.retired);
        chk("wrap_retired", bus.retired, 32'd0);

        // Reset asserted while a load is waiting in MEM_RD
        bus.op = 6'b100011;
        bus.funct = 6'b000000;
        found = 0;
        for (int k = 0; k < 10 && !found; k++) begin
            @(negedge clk);
            bus.mem_ack = (bus.state == 4'd0);
            #1;
            if (bus.state == 4'd5) found = 1;
        end
        chk("mid_rst_reached_mem_rd", 32'(found), 32'd1);
        rst = 1'b1;
        bus.mem_ack = 1'b1;
        #1;
        chk("mid_rst_state", 32'(bus.state), 32'd0);
        chk("mid_rst_mem_req", 32'(bus.mem_req), 32'd0);
        chk("mid_rst_ir_wr", 32'(bus.ir_wr), 32'd0);
        chk("mid_rst_pc_wr", 32'(bus.pc_wr), 32'd0);
        chk("mid_rst_reg_wr", 32'(bus.reg_wr), 32'd0);
        chk("mid_rst_mem_we", 32'(bus.mem_we), 32'd0);
        chk("mid_rst_illegal", 32'(bus.illegal), 32'd0);
        chk("mid_rst_retired", bus.retired, 32'd0);
        @(posedge clk);
        #1;
        chk("mid_rst_hold_mem_req", 32'(bus.mem_req), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        bus.mem_ack = 1'b0;
        #1;
        chk("post_rst_state", 32'(bus.state), 32'd0);
        chk("post_rst_mem_req", 32'(bus.mem_req), 32'd1);
        @(posedge clk);
        #1;
        chk("post_rst_fetch_wait", 32'(bus.state), 32'd0);
        $display("txn reset during MEM_RD: state=%0d retired=%0d", bus.state, bus.retired);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
